// File: rtl/npc_car_spawner.sv
// NPC car spawner for the Monaco GP playfield: waits for the start key, spawns one car
// in a pseudo-random lane after a pseudo-random gap and scrolls it down once per frame.
module npc_car_spawner #(
  parameter int          SCREEN_H     = 480,
  parameter int          ROAD_LEFT    = 200,
  parameter int          LANE_W       = 60,
  parameter int          NPC_SPEED    = 2,
  parameter int          MIN_GAP      = 30,
  parameter int          CRASH_FRAMES = 60,
  parameter logic [7:0]  START_KEY    = 8'h15
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       VGA_VS,
  input  logic [7:0] keycode,
  input  logic       gamereset,
  input  logic       hit,
  output logic [9:0] CarX,
  output logic [9:0] CarY,
  output logic       npcclk,
  output logic [7:0] spawn_count,
  output logic [1:0] o_dbg_state,
  output logic [7:0] o_dbg_lfsr
);

  localparam int GAP_W   = $clog2(MIN_GAP + 32);
  localparam int CRASH_W = $clog2(CRASH_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_ACTIVE = 2'd2,
    S_CRASH  = 2'd3
  } state_t;

  state_t             r_state, w_state_n;
  logic               r_vs_meta, r_vs_sync, r_vs_prev;
  logic               r_start;
  logic [7:0]         r_lfsr;
  logic [GAP_W-1:0]   r_gap, w_gap_n;
  logic [CRASH_W-1:0] r_crash, w_crash_n;
  logic [9:0]         r_car_x, w_car_x_n;
  logic [9:0]         r_car_y, w_car_y_n;
  logic               r_npc, w_npc_n;
  logic [7:0]         r_spawn_cnt, w_spawn_cnt_n;

  logic               w_ftick;
  logic [10:0]        w_ny;
  logic [GAP_W-1:0]   w_gap_load;
  logic [9:0]         w_lane_x;

  // A frame starts on the synchronized falling edge of vertical sync.
  assign w_ftick    = r_vs_prev & ~r_vs_sync;
  assign w_ny       = {1'b0, r_car_y} + 11'(NPC_SPEED);
  assign w_gap_load = GAP_W'(MIN_GAP) + GAP_W'(r_lfsr[4:0]);
  assign w_lane_x   = 10'(ROAD_LEFT + 10) + 10'(LANE_W) * 10'(r_lfsr[7:6]);

  always_comb begin
    w_state_n     = r_state;
    w_gap_n       = r_gap;
    w_crash_n     = r_crash;
    w_car_x_n     = r_car_x;
    w_car_y_n     = r_car_y;
    w_npc_n       = r_npc;
    w_spawn_cnt_n = r_spawn_cnt;
    if (gamereset) begin
      w_state_n = S_IDLE;
      w_npc_n   = 1'b0;
      w_car_y_n = '0;
      w_gap_n   = '0;
      w_crash_n = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_start) begin
            w_state_n = S_DELAY;
            w_gap_n   = w_gap_load;
          end
        end
        S_DELAY: begin
          if (w_ftick) begin
            if (r_gap == '0) begin
              w_state_n     = S_ACTIVE;
              w_car_x_n     = w_lane_x;
              w_car_y_n     = '0;
              w_npc_n       = 1'b1;
              w_spawn_cnt_n = r_spawn_cnt + 8'd1;
            end else begin
              w_gap_n = r_gap - GAP_W'(1);
            end
          end
        end
        S_ACTIVE: begin
          if (w_ftick) begin
            if (hit) begin
              w_state_n = S_CRASH;
              w_crash_n = CRASH_W'(CRASH_FRAMES - 1);
            end else if (w_ny >= 11'(SCREEN_H)) begin
              w_state_n = S_DELAY;
              w_gap_n   = w_gap_load;
              w_npc_n   = 1'b0;
              w_car_y_n = '0;
            end else begin
              w_car_y_n = w_ny[9:0];
            end
          end
        end
        S_CRASH: begin
          if (w_ftick) begin
            if (r_crash == '0) begin
              w_state_n = S_DELAY;
              w_gap_n   = w_gap_load;
              w_npc_n   = 1'b0;
              w_car_y_n = '0;
            end else begin
              w_crash_n = r_crash - CRASH_W'(1);
            end
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_vs_meta   <= 1'b1;
      r_vs_sync   <= 1'b1;
      r_vs_prev   <= 1'b1;
      r_start     <= 1'b0;
      r_lfsr      <= 8'hA5;
      r_gap       <= '0;
      r_crash     <= '0;
      r_car_x     <= 10'(ROAD_LEFT + 10);
      r_car_y     <= '0;
      r_npc       <= 1'b0;
      r_spawn_cnt <= '0;
    end else begin
      r_vs_meta   <= VGA_VS;
      r_vs_sync   <= r_vs_meta;
      r_vs_prev   <= r_vs_sync;
      if (keycode == START_KEY) r_start <= 1'b1;
      // Maximal-length taps, so the register never collapses to zero.
      r_lfsr      <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      r_state     <= w_state_n;
      r_gap       <= w_gap_n;
      r_crash     <= w_crash_n;
      r_car_x     <= w_car_x_n;
      r_car_y     <= w_car_y_n;
      r_npc       <= w_npc_n;
      r_spawn_cnt <= w_spawn_cnt_n;
    end
  end

  assign CarX        = r_car_x;
  assign CarY        = r_car_y;
  assign npcclk      = r_npc;
  assign spawn_count = r_spawn_cnt;
  assign o_dbg_state = r_state;
  assign o_dbg_lfsr  = r_lfsr;

endmodule

// File: tb/tb_npc_car_spawner.sv
// Bench for npc_car_spawner: random frames/keys/hits against a frame-level model whose
// expected output snapshots are queued and matched by a separate monitor.
module tb_npc_car_spawner;

  localparam int SCREEN_H = 480, ROAD_LEFT = 200, LANE_W = 60, NPC_SPEED = 2;
  localparam int MIN_GAP = 30, CRASH_FRAMES = 60;
  localparam int M_IDLE = 0, M_DELAY = 1, M_ACTIVE = 2, M_CRASH = 3;
  localparam int SNAP_W = 31;
  localparam int NSEQ = 40000;

  logic       Clk = 1'b0;
  logic       Reset_n, VGA_VS, gamereset, hit;
  logic [7:0] keycode;
  logic [9:0] CarX, CarY;
  logic       npcclk;
  logic [7:0] spawn_count;
  logic [1:0] o_dbg_state;
  logic [7:0] o_dbg_lfsr;

  npc_car_spawner dut (
    .Clk(Clk), .Reset_n(Reset_n), .VGA_VS(VGA_VS), .keycode(keycode),
    .gamereset(gamereset), .hit(hit), .CarX(CarX), .CarY(CarY), .npcclk(npcclk),
    .spawn_count(spawn_count), .o_dbg_state(o_dbg_state), .o_dbg_lfsr(o_dbg_lfsr)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk or negedge Reset_n)
    if (!Reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  // ---------------- model and scoreboard ----------------
  logic [7:0]        lfsr_seq [NSEQ];
  int                m_state, m_gap, m_crash, m_x, m_y, m_npc, m_cnt;
  bit                m_start;
  logic [SNAP_W-1:0] m_last, mon_last;
  logic [SNAP_W-1:0] exp_q[$];
  int                exp_edge_q[$];
  int                n_checks, n_pass;
  bit                mon_en;

  function automatic logic [SNAP_W-1:0] pack(int st, int cnt, int npc, int y, int x);
    return {2'(st), 8'(cnt), 1'(npc), 10'(y), 10'(x)};
  endfunction

  function automatic logic [SNAP_W-1:0] dut_snap();
    return {o_dbg_state, spawn_count, npcclk, CarY, CarX};
  endfunction

  // LFSR contents just before the given clock edge (edge 1 is the first after reset).
  function automatic logic [7:0] lfsr_before(int e);
    int i;
    i = (e < 1) ? 0 : ((e > NSEQ) ? NSEQ - 1 : e - 1);
    return lfsr_seq[i];
  endfunction

  function automatic void model_reset();
    m_state = M_IDLE; m_gap = 0; m_crash = 0; m_x = ROAD_LEFT + 10; m_y = 0;
    m_npc = 0; m_cnt = 0; m_start = 1'b0;
    m_last = pack(m_state, m_cnt, m_npc, m_y, m_x);
  endfunction

  function automatic void push_exp(int e);
    logic [SNAP_W-1:0] s;
    s = pack(m_state, m_cnt, m_npc, m_y, m_x);
    if (s != m_last) begin
      exp_q.push_back(s);
      exp_edge_q.push_back(e);
      m_last = s;
    end
  endfunction

  function automatic void enter_delay(int e);
    logic [7:0] lf;
    lf = lfsr_before(e);
    m_state = M_DELAY;
    m_gap   = MIN_GAP + int'(lf[4:0]);
    m_npc   = 0;
    m_y     = 0;
  endfunction

  function automatic void model_tick(int e, bit h);
    logic [7:0] lf;
    case (m_state)
      M_DELAY: begin
        if (m_gap == 0) begin
          lf = lfsr_before(e);
          m_state = M_ACTIVE;
          m_x = ROAD_LEFT + int'(lf[7:6]) * LANE_W + 10;
          m_y = 0; m_npc = 1; m_cnt = (m_cnt + 1) % 256;
        end else m_gap--;
      end
      M_ACTIVE: begin
        if (h) begin m_state = M_CRASH; m_crash = CRASH_FRAMES - 1; end
        else if (m_y + NPC_SPEED >= SCREEN_H) enter_delay(e);
        else m_y = m_y + NPC_SPEED;
      end
      M_CRASH: begin
        if (m_crash == 0) enter_delay(e);
        else m_crash--;
      end
      default: ;
    endcase
    push_exp(e);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
  endtask

  task automatic check_snap(input string name, input logic [SNAP_W-1:0] act,
                            input logic [SNAP_W-1:0] exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got st=%0d cnt=%0d npc=%0d y=%0d x=%0d expected st=%0d cnt=%0d npc=%0d y=%0d x=%0d (edge %0d)",
                  name, act[30:29], act[28:21], act[20], act[19:10], act[9:0],
                  exp[30:29], exp[28:21], exp[20], exp[19:10], exp[9:0], cyc);
  endtask

  task automatic monitor();
    logic [SNAP_W-1:0] act, e_snap;
    int e_edge;
    forever begin
      @(negedge Clk);
      act = dut_snap();
      if (mon_en && act !== mon_last) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_change: got %h with nothing expected (edge %0d)", act, cyc);
        end else begin
          e_snap = exp_q.pop_front();
          e_edge = exp_edge_q.pop_front();
          check_snap("outputs", act, e_snap);
          check("change_edge", cyc, e_edge);
        end
      end
      mon_last = act;
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [7:0] rnd_key();
    logic [7:0] k;
    k = 8'($urandom_range(0, 255));
    if (k == 8'h15) k = 8'h16;
    return k;
  endfunction

  task automatic frame(input bit h);
    int e;
    @(negedge Clk);
    VGA_VS = 1'b0; hit = h; keycode = rnd_key();
    e = cyc + 3;
    model_tick(e, h);
    repeat ($urandom_range(3, 5)) @(negedge Clk);
    VGA_VS = 1'b1; hit = 1'($urandom_range(0, 1));
    repeat ($urandom_range(3, 5)) @(negedge Clk);
  endtask

  task automatic key_press();
    int e;
    @(negedge Clk);
    keycode = 8'h15;
    e = cyc + 2;
    m_start = 1'b1;
    if (m_state == M_IDLE) enter_delay(e);
    push_exp(e);
    @(negedge Clk);
    keycode = rnd_key();
    @(negedge Clk);
    check("delay_after_key", int'(o_dbg_state), M_DELAY);
  endtask

  task automatic run_until_active();
    bit in_lane;
    for (int i = 0; i < 80 && m_state != M_ACTIVE; i++) frame(1'($urandom_range(0, 1)));
    in_lane = (CarX == 10'd210) || (CarX == 10'd270) || (CarX == 10'd330) || (CarX == 10'd390);
    check("spawn_npcclk", int'(npcclk), 1);
    check("spawn_lane_x", int'(in_lane), 1);
    check("spawn_count", int'(spawn_count), m_cnt);
  endtask

  task automatic gamereset_coincident();
    int c;
    @(negedge Clk);
    VGA_VS = 1'b0; hit = 1'b1; c = cyc;
    @(negedge Clk);
    @(negedge Clk);
    gamereset = 1'b1;
    m_state = M_IDLE; m_npc = 0; m_y = 0; m_gap = 0; m_crash = 0;
    push_exp(c + 3);
    @(negedge Clk);
    check("gr_state_idle", int'(o_dbg_state), M_IDLE);
    check("gr_npcclk", int'(npcclk), 0);
    check("gr_cary", int'(CarY), 0);
    @(negedge Clk);
    gamereset = 1'b0;
    if (m_start) enter_delay(c + 5);
    push_exp(c + 5);
    @(negedge Clk);
    check("gr_release_delay", int'(o_dbg_state), M_DELAY);
    hit = 1'b0; VGA_VS = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_carx"}, int'(CarX), 210);
    check({tag, "_cary"}, int'(CarY), 0);
    check({tag, "_npcclk"}, int'(npcclk), 0);
    check({tag, "_spawn_count"}, int'(spawn_count), 0);
    check({tag, "_state"}, int'(o_dbg_state), M_IDLE);
    check({tag, "_lfsr"}, int'(o_dbg_lfsr), 165);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    Reset_n = 1'b0; VGA_VS = 1'b1; keycode = 8'h00; hit = 1'b0; gamereset = 1'b0;
    mon_en = 1'b0; n_checks = 0; n_pass = 0;
    lfsr_seq[0] = 8'hA5;
    for (int i = 1; i < NSEQ; i++)
      lfsr_seq[i] = {lfsr_seq[i-1][6:0],
                     lfsr_seq[i-1][7] ^ lfsr_seq[i-1][5] ^ lfsr_seq[i-1][4] ^ lfsr_seq[i-1][3]};
    model_reset();
    mon_last = '0;
    fork monitor(); join_none

    repeat (3) @(negedge Clk);
    check_reset_vals("reset");
    Reset_n = 1'b1;
    @(negedge Clk);
    mon_en = 1'b1;

    // Without the start key nothing may move.
    repeat (100) frame(1'($urandom_range(0, 1)));
    check("nostart_npcclk", int'(npcclk), 0);
    check("nostart_spawn_count", int'(spawn_count), 0);
    check("nostart_state", int'(o_dbg_state), M_IDLE);

    // Start, spawn, full scroll and despawn.
    key_press();
    run_until_active();
    for (int i = 0; i < 260 && m_state == M_ACTIVE; i++) frame(1'b0);
    check("despawn_npcclk", int'(npcclk), 0);
    check("despawn_cary", int'(CarY), 0);
    check("despawn_state", int'(o_dbg_state), M_DELAY);

    // Crash at CarY=100: frozen for 60 ticks, the 61st re-enters DELAY.
    run_until_active();
    for (int i = 0; i < 60 && m_y != 100; i++) frame(1'b0);
    frame(1'b1);
    check("crash_state", int'(o_dbg_state), M_CRASH);
    check("crash_cary", int'(CarY), 100);
    repeat (59) frame(1'($urandom_range(0, 1)));
    check("crash_hold_cary", int'(CarY), 100);
    check("crash_hold_npcclk", int'(npcclk), 1);
    frame(1'($urandom_range(0, 1)));
    check("crash_end_npcclk", int'(npcclk), 0);
    check("crash_end_state", int'(o_dbg_state), M_DELAY);

    // gamereset beats a coincident tick and hit; restart needs no key.
    run_until_active();
    repeat (3) frame(1'b0);
    gamereset_coincident();
    run_until_active();

    // Asynchronous reset in the middle of a crash.
    repeat (4) frame(1'b0);
    frame(1'b1);
    repeat (3) frame(1'b0);
    check("pre_reset_state", int'(o_dbg_state), M_CRASH);
    check("pre_reset_queue", exp_q.size(), 0);
    mon_en = 1'b0;
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1 check_reset_vals("async");
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    @(negedge Clk);
    mon_en = 1'b1;

    key_press();
    run_until_active();
    repeat (5) frame(1'b0);

    repeat (10) @(negedge Clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
